spi_pixel_frame_ctrl: RTL and testbench
=======================================

SPI_PIXEL_FRAME_CTRL -- requirements
Module: spi_pixel_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 64, meaning number of pixel RAM entries (power of two, 2..1024).
REQ-002 SHALL have parameter ADDR_W, default 6, meaning pixel address width, equal to log2(NUM_PIXELS).
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports: clk  input  1  system clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have frame_active  input  1  SPI slave-select active, already synchronized to clk.
REQ-005 SHALL have rx_data  input  8  received SPI byte, valid when rx_ready is high.
REQ-006 SHALL have rx_ready  input  1  one-cycle pulse, new byte on rx_data.
REQ-007 SHALL have wr_en  output  1  pixel RAM write strobe.
REQ-008 SHALL have wr_addr  output  ADDR_W  pixel RAM write address.
REQ-009 SHALL have wr_data  output  24  pixel word {G,R,B}, G in bits 23:16.
REQ-010 SHALL have tx_start  output  1  one-cycle pulse that starts the NeoPixel shifter.
REQ-011 SHALL have tx_busy  input  1  NeoPixel shifter is transmitting, including reset/latch gap.
REQ-012 SHALL have pix_count  output  ADDR_W+1  number of pixels in last committed frame.
REQ-013 SHALL have frame_err  output  1  one-cycle pulse on a rejected or truncated frame.

Function
REQ-014 States SHALL be IDLE, CMD, COLLECT, WAIT_TX, START.
REQ-015 IDLE->CMD on rising edge of frame_active; a rising edge seen in WAIT_TX or START is ignored, that frame's bytes are dropped, and frame_err pulses once.
REQ-016 In CMD the first rx_ready byte SHALL be the command: 8'h01 -> COLLECT; any other value -> frame_err pulse, then IDLE after frame_active falls.
REQ-017 In COLLECT, bytes SHALL be assembled MSB-first into G,R,B order; on the third byte of a triple, wr_en is high for exactly one cycle on the next clk, with wr_addr = pixel index and wr_data = assembled word.
REQ-018 Pixel index SHALL start at 0 each frame and increment after each write; bytes beyond NUM_PIXELS triples are discarded without writing, no wrap-around, and frame_err pulses once at frame end.
REQ-019 On frame_active falling in COLLECT, with 1 or more pixels written, pix_count SHALL load the pixel count and the FSM SHALL go to WAIT_TX; with 0 pixels, return to IDLE without tx_start.
REQ-020 Leftover partial-triple bytes at frame end SHALL be discarded and SHALL pulse frame_err (except the checksum byte, REQ-026).
REQ-021 WAIT_TX SHALL hold until tx_busy is low, then go to START; START pulses tx_start for one cycle and returns to IDLE.
REQ-022 Latency: frame_active falling edge -> tx_start SHALL be 2 cycles when tx_busy is low.
REQ-023 If rx_ready and the frame_active falling edge occur in the same cycle, the byte SHALL be processed before the frame end.
REQ-024 frame_active falling in CMD SHALL return to IDLE silently.

Reset
REQ-025 While rst_n is low: state IDLE; wr_en, tx_start and frame_err are 0; wr_addr, wr_data and pix_count are 0; assembly registers are cleared. A reset mid-frame drops the frame; after release the block waits for a new rising edge of frame_active.

Configuration
REQ-026 With FRAME_CHECKSUM_EN defined, the final byte of a frame SHALL be the XOR of all preceding bytes, including the command. On mismatch, or when the byte is missing, the block SHALL issue no tx_start, pulse frame_err, and leave pix_count unchanged; RAM writes already issued stand. Without FRAME_CHECKSUM_EN, no trailing byte is expected.

Structure
REQ-027 Package pix_ctrl_pkg SHALL hold the state enum, CMD_PIXEL_WRITE = 8'h01 and the 24-bit pixel type.
REQ-028 Byte-to-pixel assembly (byte counter, shift register, XOR accumulator) SHALL be the sub-module pix_assembler; the FSM stays in the top level.

Verification
REQ-029 Frame 01,10,20,30,40,50,60 with tx_busy=0: wr_en at addr0=0x102030 and addr1=0x405060; pix_count=2; tx_start 2 cycles after frame_active falls.
REQ-030 Command byte 0x55 followed by 6 bytes: no wr_en, one frame_err pulse, no tx_start.
REQ-031 Frame of 01 plus 65 triples (NUM_PIXELS=64): 64 writes, addr 63 last, no wrap to 0, frame_err pulse, pix_count=64, tx_start.
REQ-032 tx_busy held high for 100 cycles after a valid frame: tx_start on the cycle after tx_busy falls; a second frame started meanwhile pulses frame_err and writes nothing.
REQ-033 rst_n low mid-COLLECT after 4 bytes: outputs 0 immediately; a subsequent full frame behaves as in REQ-029.
REQ-034 With FRAME_CHECKSUM_EN: 01,10,20,30 followed by checksum 0x01 -> tx_start; the same frame with checksum 0x00 -> frame_err and no tx_start.

Source files
------------

// File: rtl/spi_pixel_frame_ctrl_pkg.sv
// Shared types and constants for the SPI pixel frame controller.
// Optional build macro: FRAME_CHECKSUM_EN (trailing XOR checksum byte per frame).
package pix_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_COLLECT,
        ST_WAIT_TX,
        ST_START
    } state_t;

    localparam logic [7:0] CMD_PIXEL_WRITE = 8'h01;

    typedef logic [23:0] pixel_t;

    // Pixel word is {G,R,B}; G and R arrive first and sit in the shift register.
    function automatic pixel_t pack_pixel(input logic [15:0] gr, input logic [7:0] b);
        return {gr, b};
    endfunction

endpackage

// File: rtl/spi_pixel_frame_ctrl_if.sv
// Byte-in / pixel-RAM-out / shifter handshake bundle of the frame controller.
// Optional build macro: FRAME_CHECKSUM_EN (no effect on this bundle).
interface spi_pixel_frame_ctrl_if #(
    parameter int ADDR_W = 6
);
    import pix_ctrl_pkg::*;

    logic              frame_active;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    pixel_t            wr_data;
    logic              tx_start;
    logic [ADDR_W:0]   pix_count;
    logic              frame_err;

    modport slave (
        input  frame_active, rx_data, rx_ready, tx_busy,
        output wr_en, wr_addr, wr_data, tx_start, pix_count, frame_err
    );

    modport master (
        output frame_active, rx_data, rx_ready, tx_busy,
        input  wr_en, wr_addr, wr_data, tx_start, pix_count, frame_err
    );

endinterface

// File: rtl/spi_pixel_frame_ctrl_asm.sv
// pix_assembler: packs data bytes into {G,R,B} pixels, issues RAM writes, judges frame end.
// Optional build macro: FRAME_CHECKSUM_EN (adds the XOR accumulator and checksum test).
module pix_assembler
    import pix_ctrl_pkg::*;
#(
    parameter int NUM_PIXELS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_byte_vld,
    input  logic [7:0]        i_byte,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output pixel_t            o_wr_data,
    output logic [ADDR_W:0]   o_nxt_pix_cnt,
    output logic              o_end_commit,
    output logic              o_end_err
);

    localparam logic [ADDR_W:0] FULL_IDX = NUM_PIXELS[ADDR_W:0];

    logic [1:0]        r_byte_cnt, w_byte_cnt;
    logic [15:0]       r_shift, w_shift;
    logic [ADDR_W:0]   r_pix_idx, w_pix_idx;
    logic              r_ovf, w_ovf;
    logic              r_wr_en, w_wr_en;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
    pixel_t            r_wr_data, w_wr_data;
    logic              w_full;
    logic [7:0]        r_xor, w_xor;

    assign w_full = (r_pix_idx == FULL_IDX);

    // Once full, triples are still counted so a trailing checksum byte lands as a lone leftover.
    always_comb begin
        w_byte_cnt = r_byte_cnt;
        w_shift    = r_shift;
        w_pix_idx  = r_pix_idx;
        w_ovf      = r_ovf;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_wr_addr;
        w_wr_data  = r_wr_data;
        w_xor      = r_xor;
        if (i_start) begin
            w_byte_cnt = '0;
            w_shift    = '0;
            w_pix_idx  = '0;
            w_ovf      = 1'b0;
            w_xor      = i_byte;
        end else if (i_byte_vld) begin
            w_xor   = r_xor ^ i_byte;
            w_shift = {r_shift[7:0], i_byte};
            if (r_byte_cnt == 2'd2) begin
                w_byte_cnt = '0;
                if (w_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_pix_idx[ADDR_W-1:0];
                    w_wr_data = pack_pixel(r_shift, i_byte);
                    w_pix_idx = r_pix_idx + (ADDR_W+1)'(1);
                end
            end else begin
                w_byte_cnt = r_byte_cnt + 2'd1;
            end
        end
    end

    // Frame-end verdict uses next-cycle values so a byte arriving with the falling edge counts.
    always_comb begin
        o_nxt_pix_cnt = w_pix_idx;
`ifdef FRAME_CHECKSUM_EN
        o_end_commit = (w_byte_cnt == 2'd1) && (w_xor == '0) && (w_pix_idx != '0);
        o_end_err    = w_ovf || (w_byte_cnt != 2'd1) || (w_xor != '0);
`else
        o_end_commit = (w_pix_idx != '0);
        o_end_err    = w_ovf || (w_byte_cnt != 2'd0) || (w_xor != w_xor);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_pix_idx  <= '0;
            r_ovf      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_xor      <= '0;
        end else begin
            r_byte_cnt <= w_byte_cnt;
            r_shift    <= w_shift;
            r_pix_idx  <= w_pix_idx;
            r_ovf      <= w_ovf;
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            r_xor      <= w_xor;
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

endmodule

// File: rtl/spi_pixel_frame_ctrl.sv
// SPI pixel frame controller: frame FSM, command check, commit and NeoPixel start handshake.
// Optional build macro: FRAME_CHECKSUM_EN (frame must end with an XOR checksum byte).
module spi_pixel_frame_ctrl
    import pix_ctrl_pkg::*;
#(
    parameter int NUM_PIXELS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_pixel_frame_ctrl_if.slave bus
);

`ifdef FRAME_CHECKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    state_t          r_state, w_state_nxt;
    logic            r_fa_d;
    logic            r_frame_err;
    logic [ADDR_W:0] r_pix_count;

    logic            w_rise, w_fall, w_cmd_ok;
    logic            w_asm_start, w_asm_vld, w_pix_load, w_err_set, w_tx_start;
    logic [ADDR_W:0] w_nxt_pix_cnt;
    logic            w_end_commit, w_end_err;

    assign w_rise   = bus.frame_active && !r_fa_d;
    assign w_fall   = !bus.frame_active && r_fa_d;
    assign w_cmd_ok = (bus.rx_data == CMD_PIXEL_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_rise) w_state_nxt = ST_CMD;
            ST_CMD: begin
                if (bus.rx_ready) w_state_nxt = (w_cmd_ok && !w_fall) ? ST_COLLECT : ST_IDLE;
                else if (w_fall)  w_state_nxt = ST_IDLE;
            end
            ST_COLLECT: if (w_fall) w_state_nxt = w_end_commit ? ST_WAIT_TX : ST_IDLE;
            ST_WAIT_TX: if (!bus.tx_busy) w_state_nxt = ST_START;
            ST_START:   w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // A rejected command drops straight to IDLE; its remaining bytes are ignored until a new rising edge.
    always_comb begin
        w_tx_start  = (r_state == ST_START);
        w_asm_start = (r_state == ST_CMD) && bus.rx_ready && w_cmd_ok;
        w_asm_vld   = (r_state == ST_COLLECT) && bus.rx_ready;
        w_pix_load  = (r_state == ST_COLLECT) && w_fall && w_end_commit;
        w_err_set   = 1'b0;
        case (r_state)
            ST_CMD:     w_err_set = bus.rx_ready && (!w_cmd_ok || (w_fall && CKSUM_EN));
            ST_COLLECT: w_err_set = w_fall && w_end_err;
            ST_WAIT_TX,
            ST_START:   w_err_set = w_rise;
            default:    w_err_set = 1'b0;
        endcase
    end

    // Edge history resets high so a frame already in progress at reset release is not picked up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fa_d      <= 1'b1;
            r_frame_err <= 1'b0;
            r_pix_count <= '0;
        end else begin
            r_fa_d      <= bus.frame_active;
            r_frame_err <= w_err_set;
            if (w_pix_load) r_pix_count <= w_nxt_pix_cnt;
        end
    end

    pix_assembler #(
        .NUM_PIXELS (NUM_PIXELS),
        .ADDR_W     (ADDR_W)
    ) u_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (w_asm_start),
        .i_byte_vld    (w_asm_vld),
        .i_byte        (bus.rx_data),
        .o_wr_en       (bus.wr_en),
        .o_wr_addr     (bus.wr_addr),
        .o_wr_data     (bus.wr_data),
        .o_nxt_pix_cnt (w_nxt_pix_cnt),
        .o_end_commit  (w_end_commit),
        .o_end_err     (w_end_err)
    );

    assign bus.tx_start  = w_tx_start;
    assign bus.pix_count = r_pix_count;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_pixel_frame_ctrl.sv
// Directed bench for spi_pixel_frame_ctrl (NUM_PIXELS=64); honours FRAME_CHECKSUM_EN.
module tb_spi_pixel_frame_ctrl;

    localparam int NP = 64;
    localparam int AW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_pixel_frame_ctrl_if #(.ADDR_W(AW)) bus();

    spi_pixel_frame_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int          n_wr  = 0;
    int          n_tx  = 0;
    int          n_err = 0;
    logic [31:0] log_addr [256];
    logic [31:0] log_data [256];

    // Outputs are sampled on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (n_wr < 256) begin
                log_addr[n_wr] <= 32'(bus.wr_addr);
                log_data[n_wr] <= 32'(bus.wr_data);
            end
            n_wr <= n_wr + 1;
        end
        if (bus.tx_start === 1'b1)  n_tx  <= n_tx + 1;
        if (bus.frame_err === 1'b1) n_err <= n_err + 1;
    end

    logic [7:0] sum;
    int base_wr, base_tx, base_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        sum = sum ^ b;
        tick();
        bus.rx_ready = 1'b0;
        tick();
    endtask

    task automatic frame_begin();
        sum = '0;
        bus.frame_active = 1'b1;
        tick();
        tick();
    endtask

    task automatic frame_close();
`ifdef FRAME_CHECKSUM_EN
        send_byte(sum);
`endif
        bus.frame_active = 1'b0;
    endtask

    task automatic snap();
        base_wr  = n_wr;
        base_tx  = n_tx;
        base_err = n_err;
    endtask

    // Reference frame 01,10,20,30,40,50,60 with tx_busy low.
    task automatic ref_frame(input string tag);
        snap();
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        send_byte(8'h40); send_byte(8'h50); send_byte(8'h60);
        chk({tag, "_nwr"},   32'(n_wr - base_wr), 32'd2);
        chk({tag, "_addr0"}, log_addr[base_wr],     32'd0);
        chk({tag, "_data0"}, log_data[base_wr],     32'h102030);
        chk({tag, "_addr1"}, log_addr[base_wr + 1], 32'd1);
        chk({tag, "_data1"}, log_data[base_wr + 1], 32'h405060);
        frame_close();
        tick();
        chk({tag, "_txs_c1"}, 32'(bus.tx_start),  32'd0);
        chk({tag, "_pixcnt"}, 32'(bus.pix_count), 32'd2);
        tick();
        chk({tag, "_txs_c2"}, 32'(bus.tx_start),  32'd1);
        tick();
        chk({tag, "_txs_c3"}, 32'(bus.tx_start),  32'd0);
        chk({tag, "_ntx"},    32'(n_tx - base_tx),   32'd1);
        chk({tag, "_nerr"},   32'(n_err - base_err), 32'd0);
    endtask

    initial begin
        bus.frame_active = 1'b0;
        bus.rx_data      = '0;
        bus.rx_ready     = 1'b0;
        bus.tx_busy      = 1'b0;
        sum              = '0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_en",     32'(bus.wr_en),     32'd0);
        chk("rst_tx_start",  32'(bus.tx_start),  32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
        chk("rst_wr_data",   32'(bus.wr_data),   32'd0);
        chk("rst_pix_count", 32'(bus.pix_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        ref_frame("A");

        // Bad command byte: frame rejected, nothing written or started.
        snap();
        frame_begin();
        send_byte(8'h55);
        for (int k = 1; k <= 6; k++) send_byte(8'(k));
        frame_close();
        repeat (4) tick();
        chk("B_nwr",    32'(n_wr - base_wr),   32'd0);
        chk("B_nerr",   32'(n_err - base_err), 32'd1);
        chk("B_ntx",    32'(n_tx - base_tx),   32'd0);
        chk("B_pixcnt", 32'(bus.pix_count),    32'd2);

        // 65 triples into a 64-entry RAM: last address 63, no wrap, error at frame end.
        snap();
        frame_begin();
        send_byte(8'h01);
        for (int k = 0; k < 195; k++) send_byte(8'(k));
        chk("C_nwr",       32'(n_wr - base_wr),       32'd64);
        chk("C_first_adr", log_addr[base_wr],         32'd0);
        chk("C_first_dat", log_data[base_wr],         32'h000102);
        chk("C_last_adr",  log_addr[base_wr + 63],    32'd63);
        chk("C_last_dat",  log_data[base_wr + 63],    32'hBDBEBF);
        frame_close();
        tick();
        chk("C_txs_c1", 32'(bus.tx_start),  32'd0);
        chk("C_pixcnt", 32'(bus.pix_count), 32'd64);
        tick();
        chk("C_txs_c2", 32'(bus.tx_start),  32'd1);
        tick();
        chk("C_nwr_end", 32'(n_wr - base_wr),   32'd64);
        chk("C_nerr",    32'(n_err - base_err), 32'd1);

        // Shifter busy: commit waits, second frame during the wait is dropped with an error.
        snap();
        bus.tx_busy = 1'b1;
        frame_begin();
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        frame_close();
        repeat (10) tick();
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        frame_close();
        repeat (78) tick();
        chk("D_ntx_busy", 32'(n_tx - base_tx),   32'd0);
        chk("D_nwr",      32'(n_wr - base_wr),   32'd1);
        chk("D_data",     log_data[base_wr],     32'hAABBCC);
        chk("D_nerr",     32'(n_err - base_err), 32'd1);
        chk("D_pixcnt",   32'(bus.pix_count),    32'd1);
        chk("D_txs_pre",  32'(bus.tx_start),     32'd0);
        bus.tx_busy = 1'b0;
        tick();
        chk("D_txs_post", 32'(bus.tx_start),     32'd1);
        tick();
        chk("D_ntx_end",  32'(n_tx - base_tx),   32'd1);

        // Reset in the middle of COLLECT after four bytes.
        snap();
        frame_begin();
        send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        chk("E_pre_data", 32'(bus.wr_data), 32'h102030);
        rst_n = 1'b0;
        #1;
        chk("E_wr_en",     32'(bus.wr_en),     32'd0);
        chk("E_wr_data",   32'(bus.wr_data),   32'd0);
        chk("E_wr_addr",   32'(bus.wr_addr),   32'd0);
        chk("E_pix_count", 32'(bus.pix_count), 32'd0);
        chk("E_tx_start",  32'(bus.tx_start),  32'd0);
        chk("E_frame_err", 32'(bus.frame_err), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        bus.frame_active = 1'b0;
        repeat (4) tick();
        chk("E_ntx",  32'(n_tx - base_tx),   32'd0);
        chk("E_nerr", 32'(n_err - base_err), 32'd0);

        ref_frame("E2");

`ifdef FRAME_CHECKSUM_EN
        // Explicit checksum bytes: 0x01 is correct for 01,10,20,30.
        snap();
        bus.frame_active = 1'b1;
        tick(); tick();
        send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        send_byte(8'h01);
        bus.frame_active = 1'b0;
        tick(); tick();
        chk("F_good_txs",  32'(bus.tx_start),  32'd1);
        chk("F_good_pix",  32'(bus.pix_count), 32'd1);
        tick();
        chk("F_good_nerr", 32'(n_err - base_err), 32'd0);
        snap();
        bus.frame_active = 1'b1;
        tick(); tick();
        send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        send_byte(8'h00);
        bus.frame_active = 1'b0;
        repeat (4) tick();
        chk("F_bad_ntx",  32'(n_tx - base_tx),   32'd0);
        chk("F_bad_nerr", 32'(n_err - base_err), 32'd1);
        chk("F_bad_nwr",  32'(n_wr - base_wr),   32'd1);
        chk("F_bad_pix",  32'(bus.pix_count),    32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
